fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Producer side of the decode stage's `inst`/`pc` interface.
- Generates sequential PCs and issues reads to a synchronous instruction BRAM.
- Buffers returned words in a small queue and hands `{inst, pc}` to decode over a valid/ready handshake.
- Accepts redirects (jump/branch targets) from execute, flushing all younger fetches.

Parameters:
- RESET_PC, 32'h0000_0000, byte address of the first fetch after reset.
- IMEM_AW, 14, word-address width of the instruction BRAM.
- QDEPTH, 2, queue entries; must be 2 or more; 2 sustains one instruction per cycle.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- imem_en  out  1  read request this cycle.
- imem_addr  out  IMEM_AW  word address (byte PC[IMEM_AW+1:2]).
- imem_rdata  in  `LEN_INST  read data, valid the cycle after the request.
- o_valid  out  1  queue head holds a valid instruction.
- o_ready  in  1  decode accepts the head this cycle.
- o_inst  out  `LEN_INST  head instruction; `INST_NOP when o_valid=0.
- o_pc  out  `LEN_WORD  byte PC of o_inst; 0 when o_valid=0.
- redirect_valid  in  1  execute resolved a taken jump/branch.
- redirect_pc  in  `LEN_WORD  target byte address, bits [1:0] must be 0.

Behaviour:
- Reset (sync, rst=1 at posedge):
  - pc_q<=RESET_PC; queue empty; inflight<=0.
  - o_valid=0, o_inst=`INST_NOP (32'h0000_0013), o_pc=0, imem_en=0.
  - Any BRAM response arriving the cycle after reset is discarded.
  - Reset mid-operation behaves identically.
- Definitions:
  - fire = o_valid & o_ready.
  - occ = queue occupancy.
  - inflight = 1 if a request was issued last cycle and not cancelled.
- Issue rule (no redirect): imem_en=1 iff occ + inflight - fire < QDEPTH.
  - On issue: imem_addr=pc_q[IMEM_AW+1:2]; inflight_pc<=pc_q; pc_q<=pc_q+4 (32-bit wrap, no error).
- Response: if inflight=1, push {imem_rdata, inflight_pc} into the queue at the end of that cycle.
  - Push and pop in the same cycle are allowed.
  - The issue rule guarantees push never overflows.
- Latency: request at cycle t, BRAM data at t+1, o_valid at t+2. No bypass path.
- Throughput: 1 instr/cycle sustained with QDEPTH=2 and o_ready=1.
- Stall: o_ready=0 holds o_inst/o_pc stable; issue stops once occ+inflight reaches QDEPTH.
- Redirect (highest priority; cycle t):
  - Queue flushed at the edge.
  - The response arriving at t (from the t-1 request) is not pushed.
  - imem_en=1, imem_addr=redirect_pc[IMEM_AW+1:2] combinationally in t.
  - inflight<=1, inflight_pc<=redirect_pc, pc_q<=redirect_pc+4.
  - First valid target instruction appears at t+2.
- o_valid is not gated by redirect_valid. A fire during the redirect cycle still counts as consumed; decode/control discards it.
- Back-to-back redirects: the latest one wins; each flushes the previous target's in-flight word.
- Redirect and rst together: rst wins.
- PC overflow: 32'hFFFF_FFFC+4 wraps to 0.
- imem_addr is don't-care when imem_en=0, but must be driven from pc_q.

Optional Feature:
- Macro: FETCH_STAT_EN.
- Defined:
  - Adds outputs `stat_bubble` (32b) and `stat_flush` (32b), both 0 on reset.
  - stat_bubble increments each cycle with o_valid=0 and rst=0.
  - stat_flush increments each cycle with redirect_valid=1.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- include.vh gains:
  - `INST_NOP (32'h0000_0013)
  - `RESET_PC default
  - `LEN_IMEM_ADDR
- `LEN_INST and `LEN_WORD are reused.
- Sub-module `fetch_queue`: parameterised FIFO (DEPTH, width `LEN_INST+`LEN_WORD).
  - Ports: push/pop/flush, occ output, head data.
  - Flush has priority over push.
- fetch_unit holds pc_q, inflight tracking, the issue rule and the redirect mux.

Test Plan:
- Reset release, o_ready=1, BRAM word i = 32'h1000_0000+i -> imem_en asserts at cycle 0. o_valid first at cycle 2 with o_pc=0, o_inst=32'h1000_0000. Then o_pc increments by 4 each cycle with no bubbles.
- o_ready=0 for 5 cycles starting with head o_pc=0x8 -> o_pc stays 0x8, occ saturates at 2. Releasing ready yields 0x8, 0xC, 0x10 consecutively with no drop or duplicate.
- redirect_valid with redirect_pc=0x100 while queue is full and a request is in flight -> imem_addr=0x40 that cycle; o_valid=0 for the next cycle; next o_pc=0x100 then 0x104. Old PCs never reappear.
- Redirects to 0x200 then 0x300 on consecutive cycles -> 0x200 never appears at the output; first o_pc=0x300.
- rst pulsed for 1 cycle mid-stream with a request in flight -> o_valid=0 the next cycle; the stale word is not output; fetch restarts at RESET_PC.
- FETCH_STAT_EN defined; 3 redirects plus a 4-cycle BRAM-empty start -> stat_flush=3, stat_bubble equals the counted o_valid=0 cycles.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: instruction/word widths, NOP encoding, queue entry layout.
// Optional build macro FETCH_STAT_EN adds bubble/flush counters to fetch_unit.
`ifndef FETCH_INCLUDE_VH
`define FETCH_INCLUDE_VH
`define LEN_INST      32
`define LEN_WORD      32
`define INST_NOP      32'h0000_0013
`define RESET_PC      32'h0000_0000
`define LEN_IMEM_ADDR 14
`endif

package fetch_unit_pkg;

    localparam int INST_W = `LEN_INST;
    localparam int WORD_W = `LEN_WORD;
    localparam logic [INST_W-1:0] INST_NOP = `INST_NOP;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [WORD_W-1:0] pc;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    function automatic logic [WORD_W-1:0] pc_step(input logic [WORD_W-1:0] pc);
        return pc + WORD_W'(4);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small circular FIFO buffering fetched {inst, pc} words; flush beats push, head is read combinationally.
// Unaffected by the FETCH_STAT_EN build macro.
module fetch_queue #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    localparam int OCC_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [OCC_W-1:0] occ,
    output logic [WIDTH-1:0] head_data
);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [OCC_W-1:0] occ_reg;
    logic [DEPTH-1:0] wen;
    logic             push_eff;
    logic             pop_eff;

    assign push_eff = push & ~flush & ~srst;
    assign pop_eff  = pop & ~flush & ~srst & (occ_reg != '0);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wen
        assign wen[gi] = push_eff && (wr_ptr_reg == PTR_W'(gi));
    end

    // Payload storage needs no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wen[i]) mem_reg[i] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst || flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            occ_reg    <= '0;
        end else begin
            if (push_eff) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (pop_eff)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            occ_reg <= occ_reg + OCC_W'(push_eff) - OCC_W'(pop_eff);
        end
    end

    assign occ       = occ_reg;
    assign head_data = mem_reg[rd_ptr_reg];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: sequential PC generation, BRAM read issue, response queue and redirect handling.
// Defining FETCH_STAT_EN adds saturating stat_bubble / stat_flush counters.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = `RESET_PC,
    parameter int                IMEM_AW  = `LEN_IMEM_ADDR,
    parameter int                QDEPTH   = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [INST_W-1:0]  imem_rdata,
    output logic               o_valid,
    input  logic               o_ready,
    output logic [INST_W-1:0]  o_inst,
    output logic [WORD_W-1:0]  o_pc,
    input  logic               redirect_valid,
    input  logic [WORD_W-1:0]  redirect_pc
`ifdef FETCH_STAT_EN
    ,
    output logic [31:0]        stat_bubble,
    output logic [31:0]        stat_flush
`endif
);

    localparam int OCC_W = $clog2(QDEPTH + 1);

    logic [WORD_W-1:0] pc_q_reg;
    logic [WORD_W-1:0] inflight_pc_reg;
    logic              inflight_reg;
    logic [OCC_W-1:0]  occ;
    fetch_entry_t      head;
    fetch_entry_t      push_entry;
    logic              fire;
    logic              issue_seq;
    logic              q_push;
    logic              q_pop;
    logic              q_flush;

    assign o_valid = (occ != '0);
    assign fire    = o_valid & o_ready;

    // Budget counts words already held, plus the one returning now, minus the one leaving now.
    assign issue_seq = (int'(occ) + int'(inflight_reg) - int'(fire)) < QDEPTH;

    assign imem_en   = ~rst & (redirect_valid | issue_seq);
    assign imem_addr = redirect_valid ? redirect_pc[IMEM_AW+1:2] : pc_q_reg[IMEM_AW+1:2];

    assign push_entry = '{inst: imem_rdata, pc: inflight_pc_reg};
    assign q_flush    = rst | redirect_valid;
    assign q_push     = inflight_reg & ~q_flush;
    assign q_pop      = fire & ~q_flush;

    fetch_queue #(
        .DEPTH (QDEPTH),
        .WIDTH (ENTRY_W)
    ) u_queue (
        .clk       (clk),
        .srst      (rst),
        .push      (q_push),
        .push_data (push_entry),
        .pop       (q_pop),
        .flush     (q_flush),
        .occ       (occ),
        .head_data (head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q_reg        <= RESET_PC;
            inflight_reg    <= 1'b0;
            inflight_pc_reg <= RESET_PC;
        end else if (redirect_valid) begin
            pc_q_reg        <= pc_step(redirect_pc);
            inflight_reg    <= 1'b1;
            inflight_pc_reg <= redirect_pc;
        end else begin
            inflight_reg <= issue_seq;
            if (issue_seq) begin
                pc_q_reg        <= pc_step(pc_q_reg);
                inflight_pc_reg <= pc_q_reg;
            end
        end
    end

    assign o_inst = o_valid ? head.inst : INST_NOP;
    assign o_pc   = o_valid ? head.pc   : '0;

`ifdef FETCH_STAT_EN
    logic [31:0] stat_bubble_reg;
    logic [31:0] stat_flush_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_bubble_reg <= '0;
            stat_flush_reg  <= '0;
        end else begin
            if (!o_valid && stat_bubble_reg != '1)
                stat_bubble_reg <= stat_bubble_reg + 32'd1;
            if (redirect_valid && stat_flush_reg != '1)
                stat_flush_reg <= stat_flush_reg + 32'd1;
        end
    end

    assign stat_bubble = stat_bubble_reg;
    assign stat_flush  = stat_flush_reg;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: cycle vector table plus redirect/reset/wrap sequences and a PC scoreboard.
// With FETCH_STAT_EN defined it also checks the stat counters.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_en;
    logic [13:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        o_valid;
    logic        o_ready;
    logic [31:0] o_inst;
    logic [31:0] o_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef FETCH_STAT_EN
    logic [31:0] stat_bubble;
    logic [31:0] stat_flush;
    int          bubble_model = 0;
    int          flush_model  = 0;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    int sb_pops = 0;
    logic [31:0] exp_q [$];

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .o_valid        (o_valid),
        .o_ready        (o_ready),
        .o_inst         (o_inst),
        .o_pc           (o_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef FETCH_STAT_EN
        ,
        .stat_bubble    (stat_bubble),
        .stat_flush     (stat_flush)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous BRAM: word at address a holds 0x1000_0000 + a.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= 32'h1000_0000 + {18'd0, imem_addr};
    end

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return 32'h1000_0000 + {18'd0, pc[15:2]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted instruction outside a flush cycle must be the next expected PC.
    always @(negedge clk) begin
        #2;
        if (!rst && o_valid === 1'b1 && o_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                check("sb_extra_pc", o_pc, 32'hDEAD_BEEF);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                $display("txn pc=%h inst=%h exp_pc=%h", o_pc, o_inst, e);
                check("sb_pc", o_pc, e);
                check("sb_inst", o_inst, inst_of(e));
            end
            sb_pops++;
        end
`ifdef FETCH_STAT_EN
        if (rst) begin
            bubble_model = 0;
            flush_model  = 0;
        end else begin
            if (redirect_valid) flush_model++;
            if (o_valid !== 1'b1) bubble_model++;
        end
`endif
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic load_exp(input logic [31:0] start, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    task automatic wait_fires(input string name, input int n);
        int start;
        int k;
        start = sb_pops;
        k = 0;
        while (sb_pops < start + n && k < 50) begin
            @(negedge clk);
            k++;
        end
        #3;
        check(name, 32'(sb_pops - start >= n), 32'd1);
    endtask

    typedef struct {
        logic        rst;
        logic        ready;
        logic        chk;
        logic        en;
        logic [13:0] addr;
        logic        valid;
        logic [31:0] pc;
    } vec_t;

    vec_t vecs [14];

    initial begin
        rst = 1'b1;
        o_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;

        vecs[0]  = '{1, 1, 0, 0, 14'h0, 0, 32'h00};
        vecs[1]  = '{1, 1, 1, 0, 14'h0, 0, 32'h00};
        vecs[2]  = '{0, 1, 1, 1, 14'h0, 0, 32'h00};
        vecs[3]  = '{0, 1, 1, 1, 14'h1, 0, 32'h00};
        vecs[4]  = '{0, 1, 1, 1, 14'h2, 1, 32'h00};
        vecs[5]  = '{0, 1, 1, 1, 14'h3, 1, 32'h04};
        vecs[6]  = '{0, 0, 1, 0, 14'h0, 1, 32'h08};
        vecs[7]  = '{0, 0, 1, 0, 14'h0, 1, 32'h08};
        vecs[8]  = '{0, 0, 1, 0, 14'h0, 1, 32'h08};
        vecs[9]  = '{0, 0, 1, 0, 14'h0, 1, 32'h08};
        vecs[10] = '{0, 0, 1, 0, 14'h0, 1, 32'h08};
        vecs[11] = '{0, 1, 1, 1, 14'h4, 1, 32'h08};
        vecs[12] = '{0, 1, 1, 1, 14'h5, 1, 32'h0C};
        vecs[13] = '{0, 1, 1, 1, 14'h6, 1, 32'h10};

        load_exp(32'h0, 16);

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            rst = vecs[i].rst;
            o_ready = vecs[i].ready;
            #2;
            if (vecs[i].chk) begin
                check($sformatf("tbl_en[%0d]", i), 32'(imem_en), 32'(vecs[i].en));
                if (vecs[i].en)
                    check($sformatf("tbl_addr[%0d]", i), 32'(imem_addr), 32'(vecs[i].addr));
                check($sformatf("tbl_valid[%0d]", i), 32'(o_valid), 32'(vecs[i].valid));
                check($sformatf("tbl_pc[%0d]", i), o_pc, vecs[i].pc);
                check($sformatf("tbl_inst[%0d]", i), o_inst,
                      vecs[i].valid ? inst_of(vecs[i].pc) : 32'h0000_0013);
            end
        end
        wait_fires("stream_fires", 4);

        // Stall until the queue fills, then redirect to 0x100.
        @(negedge clk); o_ready = 1'b0;
        repeat (3) @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        load_exp(32'h100, 8);
        #2;
        check("redir1_en", 32'(imem_en), 32'd1);
        check("redir1_addr", 32'(imem_addr), 32'h40);
        @(negedge clk);
        redirect_valid = 1'b0;
        o_ready = 1'b1;
        #2;
        check("redir1_bubble", 32'(o_valid), 32'd0);
        @(negedge clk); #2;
        check("redir1_first_pc", o_pc, 32'h100);
        wait_fires("redir1_fires", 4);

        // Back-to-back redirects: only the second target may appear.
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        exp_q.delete();
        @(negedge clk);
        redirect_pc = 32'h300;
        load_exp(32'h300, 8);
        #2;
        check("redir2_addr", 32'(imem_addr), 32'hC0);
        @(negedge clk);
        redirect_valid = 1'b0;
        #2;
        check("redir2_bubble", 32'(o_valid), 32'd0);
        wait_fires("redir2_fires", 4);

        // Redirect near the top of the address space to exercise PC wrap.
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        load_exp(32'hFFFF_FFF8, 6);
        #2;
        check("wrap_addr", 32'(imem_addr), 32'h3FFE);
        @(negedge clk);
        redirect_valid = 1'b0;
        wait_fires("wrap_fires", 5);

        // One-cycle reset mid-stream with a request in flight.
        @(negedge clk);
        rst = 1'b1;
        load_exp(32'h0, 8);
        @(negedge clk);
        rst = 1'b0;
        #2;
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_pc", o_pc, 32'h0);
        check("rst_inst", o_inst, 32'h0000_0013);
        check("rst_en", 32'(imem_en), 32'd1);
        check("rst_addr", 32'(imem_addr), 32'h0);
        wait_fires("rst_fires", 4);

`ifdef FETCH_STAT_EN
        repeat (3) begin
            @(negedge clk);
            redirect_valid = 1'b1;
            redirect_pc = 32'h400;
            load_exp(32'h400, 8);
            @(negedge clk);
            redirect_valid = 1'b0;
            repeat (3) @(negedge clk);
        end
        @(negedge clk);
        #1;
        check("stat_flush", stat_flush, 32'(flush_model));
        check("stat_bubble", stat_bubble, 32'(bubble_model));
`endif

        @(negedge clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
